data_memory: RTL and testbench

Memory-access stage of the 16-bit pipeline. It sits between execute and `writeback`, and produces the `ans_dm` word that `writeback` consumes. It holds a word-addressed data RAM, performs loads and stores, and passes ALU results through for non-memory instructions. All outputs are registered, so the stage adds one pipeline cycle.

---
 rtl/data_memory.sv | 84 ++++++++
 tb/tb_data_memory.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Memory-access pipeline stage: word-addressed data RAM with registered load/store/pass-through
// results and a sticky access-error flag feeding writeback.
module data_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ans_ex,
  input  logic [15:0] data_ex,
  input  logic [2:0]  rd_ex,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        reg_wr_ex,
  input  logic        valid_ex,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] ans_dm,
  output logic [2:0]  rd_dm,
  output logic        reg_wr_dm,
  output logic        valid_dm,
  output logic        err_dm
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  logic [15:0] ram [DEPTH];

  logic [AW-1:0] idx;
  logic          in_range;
  logic          advance;
  logic          do_write;
  logic          access_err;
  logic [15:0]   result;

  assign idx      = ans_ex[AW-1:0];
  assign in_range = (ans_ex < DEPTH_W);
  // A valid instruction only takes effect when it is neither killed nor held.
  assign advance  = valid_ex && !flush && !stall;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    result     = ans_ex;
    do_write   = 1'b0;
    access_err = 1'b0;
    if (mem_wr) begin
      do_write   = advance && in_range;
      access_err = !in_range || mem_rd;
    end else if (mem_rd) begin
      result     = in_range ? ram[idx] : 16'h0000;
      access_err = !in_range;
    end
  end

  // NOTE: the RAM is cleared by reset along with the pipeline register, because software relies on it reading 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ans_dm    <= '0;
      rd_dm     <= '0;
      reg_wr_dm <= 1'b0;
      valid_dm  <= 1'b0;
      err_dm    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else if (flush || (!stall && !valid_ex)) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      ans_dm    <= '0;
      rd_dm     <= '0;
      reg_wr_dm <= 1'b0;
      valid_dm  <= 1'b0;
    end else if (advance) begin
      ans_dm    <= result;
      rd_dm     <= rd_ex;
      reg_wr_dm <= reg_wr_ex;
      valid_dm  <= 1'b1;
      err_dm    <= err_dm | access_err;
      if (do_write) begin
        ram[idx] <= data_ex;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: table of single-cycle vectors plus hand-written
// reset, combined-access error and reset-during-store sequences.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ans_ex, data_ex;
  logic [2:0]  rd_ex;
  logic        mem_rd, mem_wr, reg_wr_ex, valid_ex, stall, flush;
  logic [15:0] ans_dm;
  logic [2:0]  rd_dm;
  logic        reg_wr_dm, valid_dm, err_dm;

  int tests = 0;
  int fails = 0;

  data_memory #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset),
    .ans_ex(ans_ex), .data_ex(data_ex), .rd_ex(rd_ex),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr_ex(reg_wr_ex),
    .valid_ex(valid_ex), .stall(stall), .flush(flush),
    .ans_dm(ans_dm), .rd_dm(rd_dm), .reg_wr_dm(reg_wr_dm),
    .valid_dm(valid_dm), .err_dm(err_dm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid, rd, wr, stl, fl;
    logic [15:0] addr, data;
    logic [2:0]  rdi;
    logic        rw;
    logic [15:0] e_ans;
    logic [2:0]  e_rd;
    logic        e_rw, e_valid, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] e_ans, input logic [2:0] e_rd,
                           input logic e_rw, input logic e_valid, input logic e_err);
    check({name, ".ans_dm"}, ans_dm, e_ans);
    check({name, ".rd_dm"}, {13'd0, rd_dm}, {13'd0, e_rd});
    check({name, ".reg_wr_dm"}, {15'd0, reg_wr_dm}, {15'd0, e_rw});
    check({name, ".valid_dm"}, {15'd0, valid_dm}, {15'd0, e_valid});
    check({name, ".err_dm"}, {15'd0, err_dm}, {15'd0, e_err});
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic s, input logic f,
                       input logic [15:0] a, input logic [15:0] d, input logic [2:0] ri, input logic rw);
    valid_ex = v; mem_rd = r; mem_wr = w; stall = s; flush = f;
    ans_ex = a; data_ex = d; rd_ex = ri; reg_wr_ex = rw;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string n, input logic v, input logic r, input logic w,
                              input logic s, input logic f, input logic [15:0] a, input logic [15:0] d,
                              input logic [2:0] ri, input logic rw, input logic [15:0] ea,
                              input logic [2:0] er, input logic erw, input logic ev, input logic ee);
    vec_t t;
    t.name = n; t.valid = v; t.rd = r; t.wr = w; t.stl = s; t.fl = f;
    t.addr = a; t.data = d; t.rdi = ri; t.rw = rw;
    t.e_ans = ea; t.e_rd = er; t.e_rw = erw; t.e_valid = ev; t.e_err = ee;
    vecs.push_back(t);
  endfunction

  initial begin
    logic [15:0] pt[5];
    pt = '{16'h0005, 16'h0003, 16'h0008, 16'h0002, 16'h0001};

    //   name            v  rd wr st fl addr    data      rd rw  e_ans     erd erw ev ee
    add("ld5_after_rst", 1, 1, 0, 0, 0, 16'd5,  16'h0000, 1, 1, 16'h0000, 1, 1, 1, 0);
    add("st3",           1, 0, 1, 0, 0, 16'd3,  16'h0005, 0, 0, 16'h0003, 0, 0, 1, 0);
    add("ld3_b2b",       1, 1, 0, 0, 0, 16'd3,  16'h0000, 2, 1, 16'h0005, 2, 1, 1, 0);
    for (int i = 0; i < 5; i++)
      add("pass",        1, 0, 0, 0, 0, pt[i],  16'h0000, 3'(i), 1, pt[i], 3'(i), 1, 1, 0);
    add("st7_base",      1, 0, 1, 0, 0, 16'd7,  16'h1111, 3, 0, 16'h0007, 3, 0, 1, 0);
    add("st7_stall",     1, 0, 1, 1, 0, 16'd7,  16'hBEEF, 6, 1, 16'h0007, 3, 0, 1, 0);
    add("ld7",           1, 1, 0, 0, 0, 16'd7,  16'h0000, 4, 1, 16'h1111, 4, 1, 1, 0);
    add("st8_flush_stl", 1, 0, 1, 1, 1, 16'd8,  16'h1234, 5, 1, 16'h0000, 0, 0, 0, 0);
    add("ld8",           1, 1, 0, 0, 0, 16'd8,  16'h0000, 5, 1, 16'h0000, 5, 1, 1, 0);
    add("bubble_st2",    0, 0, 1, 0, 0, 16'd2,  16'h00FF, 5, 1, 16'h0000, 0, 0, 0, 0);
    add("ld2",           1, 1, 0, 0, 0, 16'd2,  16'h0000, 6, 1, 16'h0000, 6, 1, 1, 0);
    add("st1",           1, 0, 1, 0, 0, 16'd1,  16'h0ABC, 0, 0, 16'h0001, 0, 0, 1, 0);
    add("st64_oor",      1, 0, 1, 0, 0, 16'd64, 16'h7777, 0, 0, 16'h0040, 0, 0, 1, 1);
    add("ld0",           1, 1, 0, 0, 0, 16'd0,  16'h0000, 1, 1, 16'h0000, 1, 1, 1, 1);
    add("ld64_oor",      1, 1, 0, 0, 0, 16'd64, 16'h0000, 2, 1, 16'h0000, 2, 1, 1, 1);
    add("ld65_oor",      1, 1, 0, 0, 0, 16'd65, 16'h0000, 3, 1, 16'h0000, 3, 1, 1, 1);
    add("ld1",           1, 1, 0, 0, 0, 16'd1,  16'h0000, 3, 1, 16'h0ABC, 3, 1, 1, 1);
    add("bubble_sticky", 0, 0, 0, 0, 0, 16'd9,  16'h0000, 7, 1, 16'h0000, 0, 0, 0, 1);

    // Power-up reset, then make outputs, RAM and error non-zero.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tick();
    reset = 1'b0;
    drive(1, 0, 1, 0, 0, 16'd5, 16'hAAAA, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 16'd64, 16'h9999, 7, 1);
    tick();
    check_out("pre_reset", 16'h0040, 7, 1, 1, 1);

    // Asynchronous reset between edges: outputs clear with no clock edge.
    #2 reset = 1'b1;
    #1 check_out("async_reset", 16'h0000, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tick();
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].stl, vecs[i].fl,
            vecs[i].addr, vecs[i].data, vecs[i].rdi, vecs[i].rw);
      tick();
      check_out(vecs[i].name, vecs[i].e_ans, vecs[i].e_rd, vecs[i].e_rw, vecs[i].e_valid, vecs[i].e_err);
    end

    // Synchronous-edge reset clears the sticky error.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tick();
    reset = 1'b0;
    check_out("err_cleared", 16'h0000, 0, 0, 0, 0);

    // Load and store together: executed as a store, flags an error.
    drive(1, 1, 1, 0, 0, 16'd9, 16'h4242, 1, 0);
    tick();
    check_out("rd_wr_both", 16'h0009, 1, 0, 1, 1);
    drive(1, 1, 0, 0, 0, 16'd9, 16'h0000, 2, 1);
    tick();
    check_out("ld9_after_both", 16'h4242, 2, 1, 1, 1);

    // A store sampled on the same edge as reset is lost.
    reset = 1'b1;
    drive(1, 0, 1, 0, 0, 16'd10, 16'h5555, 0, 0);
    tick();
    reset = 1'b0;
    drive(1, 1, 0, 0, 0, 16'd10, 16'h0000, 4, 1);
    tick();
    check_out("ld10_after_rst_store", 16'h0000, 4, 1, 1, 0);
    drive(1, 1, 0, 0, 0, 16'd9, 16'h0000, 4, 1);
    tick();
    check_out("ld9_cleared", 16'h0000, 4, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
